conv2_sched: RTL
================

Name: conv2_sched

Overview:
- Sequencer for the 2-D convolution datapath. It walks every valid output window of a SIZE x SIZE input with a SIZEKer x SIZEKer kernel, stride 1, no padding.
- Per window it issues one tap read per cycle, accumulator control (clear/accumulate) and one output-write strobe with the window coordinates.
- Sits between the top-level start/done handshake and the input/kernel memories plus the MAC/accumulator of the conv2 datapath.

Parameters:
- SIZE, 5, input matrix edge length (>= SIZEKer).
- SIZEKer, 3, kernel edge length (>= 1).
- IDX_W, max(1,$clog2(SIZE)), width of every row/column index port.

Ports:
- clock  in  1  sole clock; all logic rising-edge.
- nreset  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled request; accepted only in IDLE.
- busy  out  1  high while a convolution is in progress.
- done  out  1  one-cycle pulse on completion.
- rd_en  out  1  tap read strobe to input and kernel memories.
- in_row, in_col  out  IDX_W  input-matrix address for this tap (window origin + kernel offset).
- ker_row, ker_col  out  IDX_W  kernel address for this tap.
- acc_en  out  1  accumulator update; rd_en delayed 1 cycle (memory read latency fixed at 1).
- acc_clr  out  1  with acc_en: load product instead of add (first tap of a window).
- out_we  out  1  result write strobe; accumulator holds the finished window sum.
- out_row, out_col  out  IDX_W  output-matrix coordinates, valid with out_we.

Behaviour:
- Reset (nreset=0, asynchronous): state IDLE. All outputs 0. All counters and pipeline registers 0.
- Counts:
  - N = SIZE-SIZEKer+1 windows per axis.
  - T = SIZEKer*SIZEKer taps per window.
  - N*N*T issue cycles in total.
- FSM:
  - IDLE: start=1 -> RUN next cycle; busy=1 from that cycle.
  - RUN: rd_en=1 every cycle.
    - Tap order is ker_row-major, then ker_col (kc fastest).
    - Window order is out_row-major, then out_col.
    - Last tap of last window -> DRAIN.
  - DRAIN: 2 cycles with no rd_en; lets the pipelined acc_en and out_we retire -> DONE.
  - DONE: done=1, busy=0 for one cycle -> IDLE.
- Addressing:
  - in_row = wr + kr and in_col = wc + kc, where wr/wc are the window counters and kr/kc the tap counters.
  - Indices never exceed SIZE-1.
  - Counters wrap to 0 at their limits; the carry advances the next counter.
- Pipeline:
  - acc_en(t) = rd_en(t-1).
  - acc_clr(t) = (first tap issued at t-1).
  - out_we(t) = (last tap issued at t-2).
  - out_row/out_col are the window indices delayed 2 cycles.
- Timing: with start accepted at cycle 0 and defaults:
  - rd_en cycles 1..81.
  - acc_en cycles 2..82.
  - out_we at cycles 11, 20, ..., 83.
  - done at cycle 84.
  - busy cycles 1..83.
- start while busy or in DONE: ignored; no queuing.
- start held high continuously: a new run begins the cycle after done (IDLE samples it).
- Reset mid-operation: immediate return to IDLE. Pipeline strobes are cleared the same instant, so no partial out_we after reset.

Optional Feature:
- Macro CONV2_SCHED_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in RUN or DRAIN -> next cycle rd_en, acc_en and out_we are all forced 0 and state goes to DONE.
  - done pulses, then IDLE.
  - abort is ignored in IDLE and DONE.
- Undefined: port absent; runs always complete.

Decomposition:
- Package conv_pkg holds:
  - the state enum typedef (IDLE, RUN, DRAIN, DONE);
  - functions for N and T;
  - the DRAIN_CYCLES=2 constant.
- One sub-module, conv2_idx_cnt: a 4-level nested wrap counter (kc, kr, wc, wr).
  - Inputs: en and clear.
  - Outputs: indices plus first_tap, last_tap and last_all flags.
- The FSM and the 2-stage strobe pipeline stay in conv2_sched.

Test Plan:
- Defaults, start pulse at cycle 0:
  - 81 rd_en, 81 acc_en, 9 acc_clr, 9 out_we.
  - done only at cycle 84.
  - out coordinates in order (0,0),(0,1),(0,2),(1,0)...(2,2).
- Address check:
  - Window (1,2), first tap: in_row=1, in_col=2, ker=(0,0).
  - Window (1,2), last tap: in=(3,4), ker=(2,2).
  - Golden model driven from these outputs reproduces a reference 3x3 convolution of a known 5x5 matrix.
- start re-pulsed at cycles 10 and 84 (DONE): both ignored. start held high: second run's first rd_en at cycle 86.
- nreset low at cycle 40 for 2 cycles: all outputs 0 immediately. A new start after release gives a full 81-tap run from window (0,0).
- SIZE=3, SIZEKer=3: 9 taps, single out_we at cycle 11 with (0,0), done at cycle 12.
- CONV2_SCHED_ABORT_EN: abort at cycle 30 -> no rd_en, acc_en or out_we from cycle 31; done at cycle 31; busy=0 from cycle 31.

Source files
------------

// File: rtl/conv2_sched_pkg.sv
// Shared types and constants for the conv2 sequencer.
// State encoding, window/tap count helpers and drain length.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int DRAIN_CYCLES = 2;

    function automatic int numWin(input int size, input int ker);
        return size - ker + 1;
    endfunction

    function automatic int numTaps(input int ker);
        return ker * ker;
    endfunction

endpackage

// File: rtl/conv2_idx_cnt.sv
// Nested wrap counter for the conv2 sequencer: kc fastest, then kr, wc, wr.
// Flags mark the first/last tap of a window and the very last tap overall.
module conv2_idx_cnt
    import conv_pkg::*;
#(
    parameter int SIZE    = 5,
    parameter int SIZEKer = 3,
    parameter int IDX_W   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             en,
    input  logic             clear,
    output logic [IDX_W-1:0] kr,
    output logic [IDX_W-1:0] kc,
    output logic [IDX_W-1:0] wr,
    output logic [IDX_W-1:0] wc,
    output logic             first_tap,
    output logic             last_tap,
    output logic             last_all
);

    localparam int NWIN = numWin(SIZE, SIZEKer);
    localparam logic [IDX_W-1:0] KMAX = IDX_W'(SIZEKer - 1);
    localparam logic [IDX_W-1:0] WMAX = IDX_W'(NWIN - 1);

    logic kcEnd;
    logic krEnd;
    logic wcEnd;
    logic wrEnd;

    assign kcEnd = (kc == KMAX);
    assign krEnd = (kr == KMAX);
    assign wcEnd = (wc == WMAX);
    assign wrEnd = (wr == WMAX);

    assign first_tap = (kc == '0) && (kr == '0);
    assign last_tap  = kcEnd && krEnd;
    assign last_all  = last_tap && wcEnd && wrEnd;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            kc <= '0;
            kr <= '0;
            wc <= '0;
            wr <= '0;
        end else if (clear) begin
            kc <= '0;
            kr <= '0;
            wc <= '0;
            wr <= '0;
        end else if (en) begin
            kc <= kcEnd ? '0 : kc + 1'b1;
            if (kcEnd) begin
                kr <= krEnd ? '0 : kr + 1'b1;
            end
            if (last_tap) begin
                wc <= wcEnd ? '0 : wc + 1'b1;
            end
            if (last_tap && wcEnd) begin
                wr <= wrEnd ? '0 : wr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv2_sched.sv
// Sequencer for the 2-D convolution datapath: tap reads, acc control, writes.
// Optional abort input enabled by CONV2_SCHED_ABORT_EN.
module conv2_sched
    import conv_pkg::*;
#(
    parameter int SIZE    = 5,
    parameter int SIZEKer = 3,
    parameter int IDX_W   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             start,
`ifdef CONV2_SCHED_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [IDX_W-1:0] in_row,
    output logic [IDX_W-1:0] in_col,
    output logic [IDX_W-1:0] ker_row,
    output logic [IDX_W-1:0] ker_col,
    output logic             acc_en,
    output logic             acc_clr,
    output logic             out_we,
    output logic [IDX_W-1:0] out_row,
    output logic [IDX_W-1:0] out_col
);

    state_t state;
    state_t stateNext;

    logic [1:0]       drainCnt;
    logic             drainLast;
    logic             abortHit;
    logic             cntClear;
    logic [IDX_W-1:0] kr;
    logic [IDX_W-1:0] kc;
    logic [IDX_W-1:0] wr;
    logic [IDX_W-1:0] wc;
    logic             firstTap;
    logic             lastTap;
    logic             lastAll;
    logic             weStage;
    logic [IDX_W-1:0] rowStage;
    logic [IDX_W-1:0] colStage;

`ifdef CONV2_SCHED_ABORT_EN
    assign abortHit = abort && ((state == RUN) || (state == DRAIN));
`else
    assign abortHit = 1'b0;
`endif

    assign rd_en     = (state == RUN);
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign drainLast = (drainCnt == 2'(DRAIN_CYCLES - 1));
    assign cntClear  = (state != RUN);

    conv2_idx_cnt #(
        .SIZE    (SIZE),
        .SIZEKer (SIZEKer),
        .IDX_W   (IDX_W)
    ) uIdx (
        .clock     (clock),
        .nreset    (nreset),
        .en        (rd_en),
        .clear     (cntClear),
        .kr        (kr),
        .kc        (kc),
        .wr        (wr),
        .wc        (wc),
        .first_tap (firstTap),
        .last_tap  (lastTap),
        .last_all  (lastAll)
    );

    assign in_row  = wr + kr;
    assign in_col  = wc + kc;
    assign ker_row = kr;
    assign ker_col = kc;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (abortHit) begin
                    stateNext = DONE;
                end else if (lastAll) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (abortHit || drainLast) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            drainCnt <= '0;
        end else if (state == DRAIN) begin
            drainCnt <= drainCnt + 1'b1;
        end else begin
            drainCnt <= '0;
        end
    end

    // Strobes are flushed on abort so nothing retires after the cut.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            acc_en   <= 1'b0;
            acc_clr  <= 1'b0;
            weStage  <= 1'b0;
            out_we   <= 1'b0;
            rowStage <= '0;
            colStage <= '0;
            out_row  <= '0;
            out_col  <= '0;
        end else if (abortHit) begin
            acc_en   <= 1'b0;
            acc_clr  <= 1'b0;
            weStage  <= 1'b0;
            out_we   <= 1'b0;
            rowStage <= '0;
            colStage <= '0;
            out_row  <= '0;
            out_col  <= '0;
        end else begin
            acc_en   <= rd_en;
            acc_clr  <= rd_en && firstTap;
            weStage  <= rd_en && lastTap;
            out_we   <= weStage;
            rowStage <= wr;
            colStage <= wc;
            out_row  <= rowStage;
            out_col  <= colStage;
        end
    end

endmodule
